// File: rtl/matmul_scheduler_pkg.sv
// Shared types and width helpers for the matmul scheduler slice.
// The optional abort feature is enabled by defining MM_SCHED_ABORT_EN.
package matmul_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    // Index ports stay at least one bit wide so 1-row/1-col builds remain legal.
    function automatic int unsigned addr_width(input int unsigned v);
        return (clog2(v) == 0) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/matmul_scheduler_if.sv
// Host handshake, buffer read and result write signals of the matmul scheduler.
// The abort input exists only when MM_SCHED_ABORT_EN is defined.
interface matmul_scheduler_if #(
    parameter int unsigned DIM          = 10,
    parameter int unsigned ROWS         = 4,
    parameter int unsigned COLS         = 4,
    parameter int unsigned A_DATA_WIDTH = 16,
    parameter int unsigned B_DATA_WIDTH = 16
);
    localparam int unsigned RES_WIDTH = A_DATA_WIDTH + B_DATA_WIDTH + matmul_scheduler_pkg::clog2(DIM);
    localparam int unsigned ROW_W     = matmul_scheduler_pkg::addr_width(ROWS);
    localparam int unsigned COL_W     = matmul_scheduler_pkg::addr_width(COLS);
    localparam int unsigned RES_AW    = matmul_scheduler_pkg::addr_width(ROWS * COLS);

    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 a_row_re;
    logic [ROW_W-1:0]     a_row_addr;
    logic                 b_col_re;
    logic [COL_W-1:0]     b_col_addr;
    logic [RES_WIDTH-1:0] dot_product;
    logic                 res_we;
    logic [RES_AW-1:0]    res_addr;
    logic [RES_WIDTH-1:0] res_data;
`ifdef MM_SCHED_ABORT_EN
    logic                 abort;
`endif

    modport master (
`ifdef MM_SCHED_ABORT_EN
        input  abort,
`endif
        input  start, dot_product,
        output busy, done, a_row_re, a_row_addr, b_col_re, b_col_addr,
               res_we, res_addr, res_data
    );

    modport slave (
`ifdef MM_SCHED_ABORT_EN
        output abort,
`endif
        output start, dot_product,
        input  busy, done, a_row_re, a_row_addr, b_col_re, b_col_addr,
               res_we, res_addr, res_data
    );

endinterface

// File: rtl/matmul_scheduler_tag_delay_line.sv
// Synchronous-reset shift register with flush; every stage is exposed on taps.
module tag_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            din,
    output logic [DEPTH-1:0][WIDTH-1:0] taps
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            taps <= '0;
        end else begin
            taps[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

endmodule

// File: rtl/matmul_scheduler.sv
// Sequences one C = A x B pass: row-major read issue, tag tracking, result writes.
// Defining MM_SCHED_ABORT_EN adds the abort input to stop a pass without Done.
module matmul_scheduler
    import matmul_scheduler_pkg::*;
#(
    parameter int unsigned DIM          = 10,
    parameter int unsigned ROWS         = 4,
    parameter int unsigned COLS         = 4,
    parameter int unsigned A_DATA_WIDTH = 16,
    parameter int unsigned B_DATA_WIDTH = 16,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned DP_LATENCY   = 2
) (
    input logic               clk,
    input logic               rst,
    matmul_scheduler_if.master bus
);

    localparam int unsigned ROW_W  = addr_width(ROWS);
    localparam int unsigned COL_W  = addr_width(COLS);
    localparam int unsigned RES_AW = addr_width(ROWS * COLS);
    localparam int unsigned PIPE   = MEM_LATENCY + DP_LATENCY;
    localparam int unsigned TAG_W  = RES_AW + 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    state_t                     state, state_next;
    logic [ROW_W-1:0]           row;
    logic [COL_W-1:0]           col;
    logic [RES_AW-1:0]          idx;
    logic                       kill, issue, last_pair, pending;
    logic [TAG_W-1:0]           tag_in, tail;
    logic [PIPE-1:0][TAG_W-1:0] taps;

`ifdef MM_SCHED_ABORT_EN
    assign kill = bus.abort && (state == ISSUE || state == DRAIN);
`else
    assign kill = 1'b0;
`endif

    assign issue     = (state == ISSUE) && !kill;
    assign last_pair = (row == ROW_LAST) && (col == COL_LAST);
    assign tag_in    = issue ? {1'b1, idx} : '0;
    assign tail      = taps[PIPE-1];

    tag_delay_line #(.WIDTH(TAG_W), .DEPTH(PIPE)) u_tags (
        .clk   (clk),
        .rst   (rst),
        .flush (kill),
        .din   (tag_in),
        .taps  (taps)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            if (kill) begin
                row <= '0;
                col <= '0;
                idx <= '0;
            end else if (issue) begin
                // Counters wrap back to zero after the final pair, ready for the next pass.
                col <= (col == COL_LAST) ? '0 : col + COL_W'(1);
                if (col == COL_LAST) row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                idx <= last_pair ? '0 : idx + RES_AW'(1);
            end
        end
    end

    // In DRAIN the tail retires this cycle, so the pass is over once no earlier stage holds a tag.
    always_comb begin
        pending = 1'b0;
        for (int unsigned i = 0; i + 1 < PIPE; i++) begin
            pending = pending | taps[i][TAG_W-1];
        end
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = ISSUE;
            ISSUE:   if (kill) state_next = IDLE; else if (last_pair) state_next = DRAIN;
            DRAIN:   if (kill) state_next = IDLE; else if (!pending) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.a_row_re   = issue;
    assign bus.b_col_re   = issue;
    assign bus.a_row_addr = row;
    assign bus.b_col_addr = col;
    assign bus.res_we     = tail[TAG_W-1] && !kill;
    assign bus.res_addr   = bus.res_we ? tail[RES_AW-1:0] : '0;
    assign bus.res_data   = bus.res_we ? bus.dot_product : '0;

endmodule
